// File: rtl/processor_pkg.sv
// Shared processor definitions: register file geometry, register indices
// and the program-counter reset value. Also used by the read mux and the
// control unit.
package processor_pkg;

    localparam int unsigned REG_WIDTH = 16;
    localparam int unsigned NUM_REGS  = 8;
    localparam int unsigned SEL_WIDTH = 4;

    localparam logic [SEL_WIDTH-1:0] REG_R0 = 4'd0;
    localparam logic [SEL_WIDTH-1:0] REG_R1 = 4'd1;
    localparam logic [SEL_WIDTH-1:0] REG_R2 = 4'd2;
    localparam logic [SEL_WIDTH-1:0] REG_R3 = 4'd3;
    localparam logic [SEL_WIDTH-1:0] REG_R4 = 4'd4;
    localparam logic [SEL_WIDTH-1:0] REG_R5 = 4'd5;
    localparam logic [SEL_WIDTH-1:0] REG_R6 = 4'd6;
    localparam logic [SEL_WIDTH-1:0] REG_R7 = 4'd7;
    localparam logic [SEL_WIDTH-1:0] REG_PC = REG_R7;

    localparam logic [REG_WIDTH-1:0] PC_RESET_VALUE = 16'h0000;

endpackage : processor_pkg

// File: rtl/register_bank_if.sv
// Write-port and register-output bundle between the datapath and the
// register bank. The bank takes the slave view.
interface register_bank_if;
    import processor_pkg::*;

    logic                 wrEnable;
    logic [SEL_WIDTH-1:0] wrSelect;
    logic [REG_WIDTH-1:0] wrData;
    logic                 incrPc;
    logic [REG_WIDTH-1:0] r0;
    logic [REG_WIDTH-1:0] r1;
    logic [REG_WIDTH-1:0] r2;
    logic [REG_WIDTH-1:0] r3;
    logic [REG_WIDTH-1:0] r4;
    logic [REG_WIDTH-1:0] r5;
    logic [REG_WIDTH-1:0] r6;
    logic [REG_WIDTH-1:0] r7;
    logic                 wrError;

    modport master (
        output wrEnable, wrSelect, wrData, incrPc,
        input  r0, r1, r2, r3, r4, r5, r6, r7, wrError
    );

    modport slave (
        input  wrEnable, wrSelect, wrData, incrPc,
        output r0, r1, r2, r3, r4, r5, r6, r7, wrError
    );

endinterface : register_bank_if

// File: rtl/register_bank_reg16.sv
// Single register with synchronous reset, parallel load and +1 increment.
// Priority: reset > load > incr > hold.
module reg16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] resetValue,
    input  logic             load,
    input  logic             incr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_q;

    // Register state: reset, load, increment (wraps modulo 2^WIDTH) or hold.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_q <= resetValue;
        end else if (load) begin
            r_q <= d;
        end else if (incr) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule : reg16

// File: rtl/register_bank.sv
// Eight general registers r0..r7 with one write port. r7 is the program
// counter and carries an increment path for instruction fetch; a write to
// r7 in the same cycle overrides the increment. Writes to a select with
// bit 3 set are dropped and raise a sticky error flag.
module register_bank
    import processor_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = REG_WIDTH,
    parameter int unsigned           NUM_REGS   = processor_pkg::NUM_REGS,
    parameter int unsigned           PC_INDEX   = 32'(REG_PC),
    parameter logic [DATA_WIDTH-1:0] PC_RESET   = PC_RESET_VALUE
) (
    input  logic          clock,
    input  logic          reset,
    register_bank_if.slave bus
);

    logic [NUM_REGS-1:0]   w_load;
    logic                  w_errSet;
    logic [DATA_WIDTH-1:0] w_q [NUM_REGS];
    logic                  r_wrError;

    // Write-select decode: one load strobe for a valid target, error otherwise.
    always_comb begin
        w_load   = '0;
        w_errSet = 1'b0;
        if (bus.wrEnable) begin
            if (bus.wrSelect[SEL_WIDTH-1]) begin
                w_errSet = 1'b1;
            end else begin
                w_load[bus.wrSelect[SEL_WIDTH-2:0]] = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        localparam logic [DATA_WIDTH-1:0] RST_VAL = (gi == PC_INDEX) ? PC_RESET : '0;
        logic w_incr;
        assign w_incr = (gi == PC_INDEX) ? bus.incrPc : 1'b0;

        reg16 #(.WIDTH(DATA_WIDTH)) u_reg (
            .clock      (clock),
            .reset      (reset),
            .resetValue (RST_VAL),
            .load       (w_load[gi]),
            .incr       (w_incr),
            .d          (bus.wrData),
            .q          (w_q[gi])
        );
    end

    // Sticky invalid-write flag, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wrError <= 1'b0;
        end else if (w_errSet) begin
            r_wrError <= 1'b1;
        end
    end

    assign bus.r0      = w_q[0];
    assign bus.r1      = w_q[1];
    assign bus.r2      = w_q[2];
    assign bus.r3      = w_q[3];
    assign bus.r4      = w_q[4];
    assign bus.r5      = w_q[5];
    assign bus.r6      = w_q[6];
    assign bus.r7      = w_q[7];
    assign bus.wrError = r_wrError;

endmodule : register_bank
